// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the pins,
// deserialises the 11-bit frame, and emits good bytes or an error pulse.
module ps2_rx_frame #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TimeMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   bit_in;
  logic [FW-1:0]          filt_cnt;
  logic                   filt;
  logic                   filt_del;
  logic                   strobe;
  logic [TW-1:0]          tcnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   parity;
  state_e                 state;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // The filtered clock only follows a level held for FILTER_LEN samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      filt     <= 1'b1;
      filt_del <= 1'b1;
      strobe   <= 1'b0;
    end else begin
      filt_del <= filt;
      strobe   <= filt_del & ~filt;
      if (clk_s != filt) begin
        if (filt_cnt == FiltMax) begin
          filt     <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      tcnt     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (strobe) begin
        // A strobe always beats a coincident timeout.
        tcnt <= '0;
        unique case (state)
          StIdle: begin
            if (!bit_in) begin
              state   <= StData;
              bit_cnt <= '0;
              shift   <= '0;
              busy    <= 1'b1;
            end
          end
          StData: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= StParity;
            end
          end
          StParity: begin
            parity <= bit_in;
            state  <= StStop;
          end
          StStop: begin
            if ((^{shift, parity}) && bit_in) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= StIdle;
            busy  <= 1'b0;
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == StIdle) begin
        tcnt <= '0;
      end else if (tcnt == TimeMax) begin
        tcnt   <= '0;
        rx_err <= 1'b1;
        state  <= StIdle;
        busy   <= 1'b0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good frames, back-to-back, parity/stop
// errors, glitches, timeout and mid-frame reset.
module tb_ps2_rx_frame;

  localparam int unsigned TO = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int err_cyc = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  logic [7:0] got_q[$];

  ps2_rx_frame #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_byte);
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (rx_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rx_valid === 1'b1 && rx_err === 1'b1) both_cnt++;
    if ((prev_v && rx_valid === 1'b1) || (prev_e && rx_err === 1'b1)) long_cnt++;
    prev_v = (rx_valid === 1'b1);
    prev_e = (rx_err === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    err_cnt   = 0;
    got_q.delete();
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  // Sends frame bits first..last; optional short clock glitches in each high phase.
  task automatic send_bits(input logic [10:0] f, input int first, input int last, input int glitch);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      if (glitch > 0) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc((i % 3) + 1);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 6 - ((i % 3) + 1));
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    wait_cyc(3);
    checks++;
    if (rx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte: got %h expected 00", rx_byte);
    end
    checks++;
    if ({rx_valid, rx_err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {rx_valid, rx_err, busy});
    end
    rst = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_good_frame();
    logic [10:0] f;
    clear_mon();
    f = mk(8'h1D, 1'b0, 1'b1);
    send_bits(f, 0, 2, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid: got %b expected 1", busy);
    end
    send_bits(f, 3, 10, 0);
    wait_cyc(5);
    checks++;
    if (valid_cnt !== 1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL good_counts: got valid %0d err %0d expected 1 0", valid_cnt, err_cnt);
    end
    checks++;
    if (rx_byte !== 8'h1D) begin
      errors++;
      $display("FAIL good_byte: got %h expected 1d", rx_byte);
    end
    checks++;
    if (valid_cyc - last_fall - 1 !== 7) begin
      errors++;
      $display("FAIL good_latency: got %0d expected 7", valid_cyc - last_fall - 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'hF0;
    exp[1] = 8'h1D;
    exp[2] = 8'h29;
    clear_mon();
    for (int k = 0; k < 3; k++) send_bits(mk(exp[k], 1'b0, 1'b1), 0, 10, 0);
    wait_cyc(5);
    checks++;
    if (valid_cnt !== 3 || err_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_counts: got valid %0d err %0d expected 3 0", valid_cnt, err_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q.size() <= k || got_q[k] !== exp[k]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h expected %h", k,
                 (got_q.size() > k) ? got_q[k] : 8'hxx, exp[k]);
      end
    end
  endtask

  task automatic test_errors();
    clear_mon();
    send_bits(mk(8'h23, 1'b1, 1'b1), 0, 10, 0);
    wait_cyc(5);
    checks++;
    if (err_cnt !== 1 || err_cyc - last_fall !== 8) begin
      errors++;
      $display("FAIL parity_err: got count %0d delay %0d expected 1 8", err_cnt,
               err_cyc - last_fall);
    end
    send_bits(mk(8'h23, 1'b0, 1'b0), 0, 10, 0);
    ps2_data = 1'b1;
    wait_cyc(5);
    checks++;
    if (err_cnt !== 2 || valid_cnt !== 0) begin
      errors++;
      $display("FAIL stop_err: got err %0d valid %0d expected 2 0", err_cnt, valid_cnt);
    end
    checks++;
    if (rx_byte !== 8'h29) begin
      errors++;
      $display("FAIL err_hold: got %h expected 29", rx_byte);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    for (int g = 1; g <= 3; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(g);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    checks++;
    if (busy !== 1'b0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL idle_glitch: got busy %b err %0d expected 0 0", busy, err_cnt);
    end
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, 1);
    wait_cyc(5);
    checks++;
    if (valid_cnt !== 1 || err_cnt !== 0 || rx_byte !== 8'h1C) begin
      errors++;
      $display("FAIL glitch_frame: got valid %0d err %0d byte %h expected 1 0 1c",
               valid_cnt, err_cnt, rx_byte);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_bits(mk(8'h55, 1'b0, 1'b1), 0, 5, 0);
    ps2_data = 1'b1;
    for (int i = 0; i < int'(TO) + 100; i++) begin
      if (err_cnt > 0) break;
      wait_cyc(1);
    end
    checks++;
    if (err_cnt !== 1 || err_cyc - last_fall !== 8 + int'(TO)) begin
      errors++;
      $display("FAIL timeout_err: got count %0d delay %0d expected 1 %0d", err_cnt,
               err_cyc - last_fall, 8 + int'(TO));
    end
    checks++;
    if (busy !== 1'b0 || valid_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_state: got busy %b valid %0d expected 0 0", busy, valid_cnt);
    end
    send_bits(mk(8'h1B, 1'b0, 1'b1), 0, 10, 0);
    wait_cyc(5);
    checks++;
    if (valid_cnt !== 1 || rx_byte !== 8'h1B) begin
      errors++;
      $display("FAIL after_timeout: got valid %0d byte %h expected 1 1b", valid_cnt, rx_byte);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_bits(mk(8'hAA, 1'b0, 1'b1), 0, 4, 0);
    wait_cyc(2);
    rst = 1'b0;
    #1;
    checks++;
    if (rx_byte !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got byte %h busy %b expected 00 0", rx_byte, busy);
    end
    ps2_data = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(int'(TO) + 200);
    checks++;
    if (valid_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL reset_pulses: got valid %0d err %0d expected 0 0", valid_cnt, err_cnt);
    end
    send_bits(mk(8'h29, 1'b0, 1'b1), 0, 10, 0);
    wait_cyc(5);
    checks++;
    if (valid_cnt !== 1 || rx_byte !== 8'h29) begin
      errors++;
      $display("FAIL after_reset: got valid %0d byte %h expected 1 29", valid_cnt, rx_byte);
    end
  endtask

  task automatic test_pulse_shape();
    checks++;
    if (both_cnt !== 0 || long_cnt !== 0) begin
      errors++;
      $display("FAIL pulse_shape: got both %0d long %0d expected 0 0", both_cnt, long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_errors();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
